mux4_scan_serializer: RTL and testbench

- Sequential controller that drives a 4:1 bit-select mux and consumes its output.
- Accepts a 4-bit word via valid/ready and holds it on `word` while stepping the 2-bit `sel` through indices 0..3.
- Samples the returned `mux_out` bit once per bit period and emits it as a serial stream with a valid strobe.
- Sits between a parallel word source and a 1-bit serial consumer (LED or pin driver, shift register).

---
 rtl/mux4_scan_serializer_pkg.sv | 17 +
 rtl/mux4_scan_serializer_if.sv | 28 ++
 rtl/mux4_scan_serializer_bit_period_timer.sv | 29 ++
 rtl/mux4_scan_serializer.sv | 90 +++++++++
 tb/tb_mux4_scan_serializer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_scan_serializer_pkg.sv
// Shared types and constants for the 4:1 mux scan serializer.
package mux4_scan_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WORD_BITS = 4;
  localparam int SEL_BITS  = 2;

  // Width of the per-bit tick counter; never narrower than one bit.
  function automatic int tick_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mux4_scan_serializer_if.sv
// Load handshake, mux loop and serial output bundle of the scan serializer.
interface mux4_scan_serializer_if;
  import mux4_scan_serializer_pkg::*;

  logic                  load_valid;
  logic                  load_ready;
  logic [0:WORD_BITS-1]  load_data;
  logic                  abort;
  logic [0:WORD_BITS-1]  word;
  logic [0:SEL_BITS-1]   sel;
  logic                  mux_out;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  done;

  // master: word source, external mux and serial consumer
  modport master (
    output load_valid, load_data, abort, mux_out,
    input  load_ready, word, sel, ser_out, ser_valid, done
  );

  // slave: the serializer itself
  modport slave (
    input  load_valid, load_data, abort, mux_out,
    output load_ready, word, sel, ser_out, ser_valid, done
  );

endinterface

// File: rtl/mux4_scan_serializer_bit_period_timer.sv
// Bit-period tick counter: counts 0..BIT_CYCLES-1 and flags the last tick.
module mux4_scan_serializer_bit_period_timer
  import mux4_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick_last
);

  localparam int            TW   = tick_width(BIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] tick;

  assign tick_last = (tick == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick <= '0;
    end else if (en) begin
      tick <= tick_last ? '0 : tick + TW'(1);
    end
  end

endmodule

// File: rtl/mux4_scan_serializer.sv
// Holds a 4-bit word on the external mux, walks sel 0..3 and streams the
// returned mux bit out serially, one bit per BIT_CYCLES clocks.
//
// state | meaning
// IDLE  | load_ready high, sel parked at 00, waiting for a word
// SHIFT | word held, sel = bit index, sampling mux_out each bit period
module mux4_scan_serializer
  import mux4_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  mux4_scan_serializer_if.slave bus
);

  localparam logic [SEL_BITS-1:0] LAST_INDEX = SEL_BITS'(WORD_BITS - 1);

  state_t                state;
  logic [0:WORD_BITS-1]  word_q;
  logic [SEL_BITS-1:0]   index;
  logic                  ser_out_q;
  logic                  ser_valid_q;
  logic                  done_q;
  logic                  tick_last;
  logic                  timer_clear;
  logic                  timer_en;

  // Abort restarts the bit period so a later word starts from tick 0.
  assign timer_clear = (state == IDLE) || bus.abort;
  assign timer_en    = (state == SHIFT);

  mux4_scan_serializer_bit_period_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .en        (timer_en),
    .tick_last (tick_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_q      <= '0;
      index       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load_valid && !bus.abort) begin
            word_q <= bus.load_data;
            index  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            index <= '0;
            state <= IDLE;
          end else if (tick_last) begin
            ser_out_q   <= bus.mux_out;
            ser_valid_q <= 1'b1;
            if (index == LAST_INDEX) begin
              done_q <= 1'b1;
              index  <= '0;
              state  <= IDLE;
            end else begin
              index <= index + SEL_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.word       = word_q;
  assign bus.sel[0]     = index[0];
  assign bus.sel[1]     = index[1];
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mux4_scan_serializer.sv
// Scoreboard bench: three serializers (BIT_CYCLES 1, 2, 3) each closing the
// loop through a behavioural 4:1 mux, checked against a timeline model.
module tb_mux4_scan_serializer;
  import mux4_scan_serializer_pkg::*;

  localparam int N = 3;

  typedef struct {
    int   t;
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] lv    = '0;
  logic [N-1:0] ab    = '0;
  logic [N-1:0] rst_v = '1;
  logic [0:3]   ld [N];

  logic [N-1:0] m_ready, m_valid, m_sout, m_done;
  logic [0:3]   m_word [N];
  logic [0:1]   m_sel  [N];

  for (genvar g = 0; g < N; g++) begin : g_inst
    mux4_scan_serializer_if bus ();
    assign bus.load_valid = lv[g];
    assign bus.load_data  = ld[g];
    assign bus.abort      = ab[g];
    assign bus.mux_out    = bus.word[{bus.sel[1], bus.sel[0]}];
    assign m_ready[g]     = bus.load_ready;
    assign m_valid[g]     = bus.ser_valid;
    assign m_sout[g]      = bus.ser_out;
    assign m_done[g]      = bus.done;
    assign m_word[g]      = bus.word;
    assign m_sel[g]       = bus.sel;

    mux4_scan_serializer #(.BIT_CYCLES(g + 1)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  // Reference model state and scoreboard (owned by the model process)
  exp_t       q [N][$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         acc_cnt  [N] = '{default: 0};
  int         acc_edge [N] = '{default: 0};
  logic [0:3] mword    [N] = '{default: '0};
  logic       last_bit [N] = '{default: 1'b0};
  int         tmo_raised = 0;
  int         tmo_seen = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, i, cyc, act, req);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst_v[i]) begin
        q[i].delete();
        mword[i]    = '0;
        last_bit[i] = 1'b0;
      end else if (q[i].size() != 0) begin
        if (ab[i]) q[i].delete();
      end else if (lv[i] && !ab[i]) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          e.t    = cyc + (k + 1) * (i + 1);
          e.b    = ld[i][k];
          e.last = (k == 3);
          q[i].push_back(e);
        end
        mword[i]    = ld[i];
        acc_edge[i] = cyc;
        acc_cnt[i]++;
      end
    end

    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      logic exp_v, exp_d;
      int   exp_idx;
      exp_v = (q[i].size() != 0) && (q[i][0].t == cyc);
      exp_d = 1'b0;
      if (exp_v) begin
        exp_t e;
        e           = q[i].pop_front();
        last_bit[i] = e.b;
        exp_d       = e.last;
      end
      exp_idx = (q[i].size() == 0) ? 0 : 4 - q[i].size();
      chk("ser_valid",  i, 32'(m_valid[i]), 32'(exp_v));
      chk("done",       i, 32'(m_done[i]),  32'(exp_d));
      chk("ser_out",    i, 32'(m_sout[i]),  32'(last_bit[i]));
      chk("load_ready", i, 32'(m_ready[i]), 32'(q[i].size() == 0));
      chk("sel_index",  i, 32'({m_sel[i][1], m_sel[i][0]}), 32'(exp_idx));
      chk("word",       i, 32'(m_word[i]),  32'(mword[i]));
    end
    chk("stim_timeout", -1, 32'(tmo_raised - tmo_seen), 32'd0);
    tmo_seen = tmo_raised;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [0:3] d);
    int c0 = acc_cnt[i];
    int n  = 0;
    ld[i] = d;
    lv[i] = 1'b1;
    while (acc_cnt[i] == c0 && n < 100) begin
      step();
      n++;
    end
    if (acc_cnt[i] == c0) tmo_raised++;
    lv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (q[i].size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (q[i].size() != 0) tmo_raised++;
    step();
  endtask

  // Abort lands on the sampling edge of bit k of the word just accepted.
  task automatic abort_at_bit(input int i, input int k);
    int target = acc_edge[i] + (k + 1) * (i + 1);
    while (cyc < target - 1) step();
    ab[i] = 1'b1;
    step();
    ab[i] = 1'b0;
  endtask

  task automatic reset_after(input int i, input int w);
    repeat (w) step();
    rst_v[i] = 1'b1;
    step();
    rst_v[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ld[i] = '0;
    repeat (3) step();
    rst_v = '0;
    step();

    // Closed-loop word, then a held back-to-back pair
    send(0, 4'b1011);
    wait_idle(0);
    send(0, 4'b1000);
    send(0, 4'b0001);
    wait_idle(0);

    // Load attempts blocked by abort in IDLE
    ld[0] = 4'b0110;
    lv[0] = 1'b1;
    ab[0] = 1'b1;
    repeat (3) step();
    lv[0] = 1'b0;
    ab[0] = 1'b0;
    step();

    // Slow bit period
    send(2, 4'b0110);
    wait_idle(2);

    // Abort on the bit-2 sampling edge
    send(1, 4'b1111);
    abort_at_bit(1, 2);
    step();

    // Reset after one bit, then a full word
    send(2, 4'b1100);
    reset_after(2, 3);
    send(2, 4'b0101);
    wait_idle(2);

    // Randomised words with gaps, aborts, resets and back-to-back loads
    for (int i = 0; i < N; i++) begin
      for (int n = 0; n < 25; n++) begin
        int r;
        repeat ($urandom_range(0, 2)) step();
        send(i, 4'($urandom_range(0, 15)));
        r = $urandom_range(0, 9);
        if (r == 0)      abort_at_bit(i, $urandom_range(0, 3));
        else if (r == 1) reset_after(i, $urandom_range(0, 4 * (i + 1) - 1));
        else if (r >= 5) wait_idle(i);
      end
      wait_idle(i);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
